// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised FIFO controller.
package fifo_pkg;

  localparam int unsigned MAX_VAL_DEF = 9;

  // Request-forming mode: act on a rising edge or on the level each cycle.
  typedef enum logic {
    LEVEL = 1'b0,
    EDGE  = 1'b1
  } edge_mode_e;

  // True when slot idx lies within count entries of head, walking forward
  // around a ring of depth slots (depth is a power of two).
  function automatic logic slot_live(input int unsigned idx,
                                     input int unsigned head,
                                     input int unsigned count,
                                     input int unsigned depth);
    return ((idx - head) & (depth - 1)) < count;
  endfunction

endpackage

// File: rtl/fifo_ctrl_param_if.sv
// Handshake, register-file and status bundle of the FIFO controller.
interface fifo_ctrl_param_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] rd;
  logic [AW-1:0]    ra;
  logic             we;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] out;
  logic             out_vld;
  logic             emp;
  logic             full;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      count;
  logic [AW-1:0]    head;
  logic [DEPTH-1:0] valid;
  logic             drop;
  logic             udf;

  // Controller side.
  modport slave (
    input  push, pop, in, rd,
    output ra, we, wa, wd, out, out_vld, emp, full, almost_full,
           almost_empty, count, head, valid, drop, udf
  );

  // Producer / register-file / display side.
  modport master (
    output push, pop, in, rd,
    input  ra, we, wa, wd, out, out_vld, emp, full, almost_full,
           almost_empty, count, head, valid, drop, udf
  );

endinterface

// File: rtl/req_edge.sv
// Turns a push/pop input into a one-cycle request, by edge or by level.
module req_edge
  import fifo_pkg::*;
#(
  parameter edge_mode_e MODE = EDGE
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  output logic o_req_c
);

  logic r_q;

  // Previous input; resets high so a level held through reset is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= 1'b1;
    else     r_q <= i_req;
  end

  assign o_req_c = (MODE == EDGE) ? (i_req & ~r_q) : i_req;

endmodule

// File: rtl/fifo_ctrl_param.sv
// FIFO control unit for an external DEPTH x WIDTH register file.
module fifo_ctrl_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter int unsigned MAX_VAL  = MAX_VAL_DEF,
  parameter int unsigned EDGE_DET = 1,
  parameter int unsigned AF_LVL   = DEPTH - 1,
  parameter int unsigned AE_LVL   = 1
) (
  input logic             clk,
  input logic             rst,
  fifo_ctrl_param_if.slave bus
);

  localparam int unsigned CW = AW + 1;
  localparam edge_mode_e  REQ_MODE = (EDGE_DET != 0) ? EDGE : LEVEL;

  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_out;
  logic             r_out_vld;
  logic             r_drop;
  logic             r_udf;

  logic             w_push_req;
  logic             w_pop_req;
  logic             w_in_range;
  logic             w_not_full;
  logic             w_is_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [CW-1:0]    w_count_nxt;
  logic [DEPTH-1:0] w_valid;

  req_edge #(.MODE(REQ_MODE)) u_push_req (
    .clk     (clk),
    .rst     (rst),
    .i_req   (bus.push),
    .o_req_c (w_push_req)
  );

  req_edge #(.MODE(REQ_MODE)) u_pop_req (
    .clk     (clk),
    .rst     (rst),
    .i_req   (bus.pop),
    .o_req_c (w_pop_req)
  );

  // Acceptance: a full FIFO takes a push only when a pop frees the slot.
  assign w_is_empty = (r_count == '0);
  assign w_not_full = (r_count != CW'(DEPTH));
  assign w_in_range = (32'(bus.in) <= MAX_VAL);
  assign w_pop_ok   = w_pop_req & ~w_is_empty;
  assign w_push_ok  = w_push_req & w_in_range & (w_not_full | w_pop_ok);

  // Occupancy next value; push and pop together leave it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, count, popped data and event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_out     <= '0;
      r_out_vld <= 1'b0;
      r_drop    <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      if (w_pop_ok) begin
        r_head <= r_head + AW'(1);
        r_out  <= bus.rd;
      end
      if (w_push_ok) r_tail <= r_tail + AW'(1);
      r_count   <= w_count_nxt;
      r_out_vld <= w_pop_ok;
      r_drop    <= w_push_req & ~w_push_ok;
      r_udf     <= w_pop_req & w_is_empty;
    end
  end

  // Per-slot occupancy from the circular distance to head.
  always_comb begin
    w_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_valid[i] = slot_live(i, 32'(r_head), 32'(r_count), DEPTH);
    end
  end

  assign bus.ra           = r_head;
  assign bus.we           = w_push_ok;
  assign bus.wa           = r_tail;
  assign bus.wd           = bus.in;
  assign bus.out          = r_out;
  assign bus.out_vld      = r_out_vld;
  assign bus.emp          = w_is_empty;
  assign bus.full         = ~w_not_full;
  assign bus.almost_full  = (32'(r_count) >= AF_LVL);
  assign bus.almost_empty = (32'(r_count) <= AE_LVL);
  assign bus.count        = r_count;
  assign bus.head         = r_head;
  assign bus.valid        = w_valid;
  assign bus.drop         = r_drop;
  assign bus.udf          = r_udf;

endmodule

// File: doc/fifo_ctrl_param.md
Name: fifo_ctrl_param

Overview:
- Parametrised FIFO control unit driving an external DEPTH x WIDTH register file through a read port (ra/rd) and a write port (we/wa/wd).
- Next generation of the lab2 FIFO controller. Adds generic width and depth, an occupancy count, almost-full/almost-empty flags, and accepted simultaneous push+pop.
- Adds pulses for rejected pushes and pops, and a selectable edge-detect or level (one request per cycle) input mode.
- Sits between debounced button/switch inputs (or an upstream producer) and the register file plus display logic, which consumes valid/head.

Parameters:
- WIDTH, 4, data width in bits.
- DEPTH, 8, entries; must be a power of 2, at least 2.
- AW, $clog2(DEPTH), address width (derived; do not override).
- MAX_VAL, 9, largest accepted input value; push with in > MAX_VAL is rejected.
- EDGE_DET, 1, 1 = push/pop act on rising edge; 0 = act on level, once per cycle.
- AF_LVL, DEPTH-1, almost_full asserted when count >= AF_LVL.
- AE_LVL, 1, almost_empty asserted when count <= AE_LVL.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- push  in  1  push request.
- pop  in  1  pop request.
- in  in  WIDTH  push data.
- rd  in  WIDTH  register-file read data (combinational from ra).
- ra  out  AW  register-file read address, equal to head.
- we  out  1  register-file write enable (combinational).
- wa  out  AW  register-file write address, equal to tail.
- wd  out  WIDTH  register-file write data, equal to in.
- out  out  WIDTH  last popped value (registered).
- out_vld  out  1  one-cycle pulse, cycle after an accepted pop.
- emp  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_LVL.
- almost_empty  out  1  count <= AE_LVL.
- count  out  AW+1  occupancy, 0..DEPTH.
- head  out  AW  index of oldest entry.
- valid  out  DEPTH  per-slot occupancy mask.
- drop  out  1  one-cycle pulse: push request rejected.
- udf  out  1  one-cycle pulse: pop request while empty.

Behaviour:
- Reset (async, immediate): head=0, tail=0, count=0, out=0, out_vld=0, drop=0, udf=0.
- After reset: emp=1, full=0, almost_empty=1, almost_full=(AF_LVL==0), valid=0.
- Edge registers reset to 1, so a button held through reset release does not produce an event.
- Request: push_req = EDGE_DET ? push & ~push_q : push; pop_req is formed the same way from pop.
- Pointers increment and wrap modulo DEPTH via natural AW-bit overflow. tail = next write slot.
- pop_ok = pop_req & (count != 0).
- push_ok = push_req & (in <= MAX_VAL) & ((count != DEPTH) | pop_ok). When full, a push is accepted only alongside an accepted pop.
- we = push_ok (combinational, same cycle as the request). The register file writes at the clk edge.
- Accepted pop: out <= rd (value at old head) at the edge; out_vld=1 for the following cycle; head <= head+1.
- Accepted push: tail <= tail+1.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Empty + push + pop: pop rejected (udf=1), push accepted, count becomes 1. There is no bypass to out.
- Full + push + pop: both accepted. The old head value reaches out while the new value writes at the same slot index. The register file must read-before-write, which holds because rd is sampled before the edge.
- drop=1 the cycle after a push_req that is not push_ok (range violation or full without pop).
- udf=1 the cycle after a pop_req with count == 0.
- emp, full, almost_full, almost_empty are decoded combinationally from registered count.
- valid[i] = ((i - head) mod DEPTH) < count, using AW-bit subtraction. Therefore full gives all ones and empty gives all zeros.
- All registers are updated on the same posedge; there are no multicycle paths.
- Reset mid-operation discards contents logically; the register file itself is not cleared.

Decomposition:
- Shared package fifo_pkg: MAX_VAL default, the edge-mode enumeration (EDGE/LEVEL), and a function for the circular-distance compare used by valid.
- One sub-module: req_edge (registered edge/level request former with reset-to-1), instantiated twice for push and pop.
- Pointer, count and flag logic stays in the top module.

Test Plan:
- DEPTH=8, reset, push 1..8 as edges -> count=8, full=1, almost_full=1, valid=8'hFF. A 9th push gives drop=1 and count stays 8.
- From full, 8 pops -> out sequence 1..8, each with an out_vld pulse. Then emp=1, head=0, and a 9th pop gives udf=1 with out holding 8.
- Push 5, 12, 3 -> the 12 is rejected (drop=1, we=0); count=2, and pops return 5 then 3.
- Wrap test: push 6, pop 6, push 4 -> head=6, tail=2, count=4, valid=8'b1100_0011.
- Full with simultaneous push 7 + pop (EDGE_DET=0) -> out=oldest value, count stays 8, and the new tail slot holds 7. Empty with push+pop -> udf=1 and count=1.
- Hold push high, pulse rst mid-stream, release -> all outputs at reset values, no push event until push falls and rises again. With EDGE_DET=0 and push held 3 cycles, count=3.
